// File: rtl/lsu_queue.sv
`timescale 1ns/1ps
// In-order load/store queue: buffers DEPTH requests, splits misaligned words
// into two bus beats and returns merged read data with the transaction id.
module lsu_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TID_W  = 1
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic [ADDR_W-1:0] rq_addr,
  input  logic              rq_wr_addr,
  input  logic [DATA_W-1:0] rq_data,
  input  logic              rq_width,
  input  logic              rq_cmd,
  input  logic [TID_W-1:0]  rq_t_id,
  input  logic              rq_start,
  output logic              rq_ack,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_cmd,
  output logic [DATA_W/8-1:0] mem_be,
  output logic              mem_bus_assert,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TID_W-1:0]  rsp_t_id,
  output logic              lsu_idle
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SH_W  = $clog2(DATA_W) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              width;
    logic              cmd;
    logic [TID_W-1:0]  tid;
  } entry_t;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  entry_t            q_mem [DEPTH];
  entry_t            head_e;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] last_addr, addr_in, base;
  logic [DATA_W-1:0] partial, shifted, merged;
  logic [OFF_W-1:0]  off;
  logic [SH_W-1:0]   sh_lo, sh_hi;
  logic [BYTES-1:0]  ones;
  logic              full, push, pop, split, beat_done, last_beat, more;
  state_t            state, state_nxt;

  assign full      = (count == CNT_W'(DEPTH));
  assign rq_ack    = rq_start & ~full;
  assign push      = rq_ack;
  assign addr_in   = rq_wr_addr ? rq_addr : last_addr;
  assign head_e    = q_mem[head];
  assign off       = head_e.addr[OFF_W-1:0];
  assign base      = {head_e.addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign sh_lo     = SH_W'({off, 3'b000});
  assign sh_hi     = SH_W'(DATA_W) - sh_lo;
  assign ones      = '1;
  assign split     = ~head_e.width & (off != '0);
  assign beat_done = mem_bus_assert & mem_rdy;
  assign last_beat = (state == BEAT1) | ((state == BEAT0) & ~split);
  assign pop       = beat_done & last_beat;
  // Another entry will be head after this pop (possibly the one arriving now).
  assign more      = (count > CNT_W'(1)) | push;
  assign lsu_idle  = (count == '0) & ~mem_bus_assert & ~rsp_valid;

  // Next-state and beat decode from the head entry.
  always_comb begin
    state_nxt      = state;
    mem_bus_assert = 1'b0;
    mem_addr       = base;
    mem_wdata      = '0;
    mem_cmd        = 1'b0;
    mem_be         = '0;
    case (state)
      IDLE: begin
        if ((count != '0) | push) state_nxt = BEAT0;
      end
      BEAT0: begin
        mem_bus_assert = 1'b1;
        mem_cmd        = head_e.cmd;
        if (head_e.width) begin
          mem_be    = BYTES'(1) << off;
          mem_wdata = DATA_W'(head_e.data[7:0]) << sh_lo;
        end else begin
          mem_be    = ones << off;
          mem_wdata = head_e.data << sh_lo;
        end
        if (beat_done) state_nxt = split ? BEAT1 : (more ? BEAT0 : IDLE);
      end
      BEAT1: begin
        mem_bus_assert = 1'b1;
        mem_cmd        = head_e.cmd;
        mem_addr       = base + ADDR_W'(BYTES);
        mem_be         = ~(ones << off);
        mem_wdata      = head_e.data >> sh_hi;
        if (beat_done) state_nxt = more ? BEAT0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data alignment: beat0 lanes shift down, beat1 lanes fill the top.
  always_comb begin
    shifted = mem_rdata >> sh_lo;
    if (state == BEAT1)    merged = partial | (mem_rdata << sh_hi);
    else if (head_e.width) merged = DATA_W'(shifted[7:0]);
    else                   merged = shifted;
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[tail] <= {addr_in, rq_data, rq_width, rq_cmd, rq_t_id};
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      last_addr <= '0;
      partial   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_t_id  <= '0;
    end else begin
      state <= state_nxt;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        tail      <= tail + PTR_W'(1);
        last_addr <= addr_in;
      end
      if (pop) head <= head + PTR_W'(1);
      if (beat_done && (state == BEAT0) && split) partial <= shifted;
      rsp_valid <= pop;
      if (pop) begin
        rsp_t_id <= head_e.tid;
        rsp_data <= head_e.cmd ? '0 : merged;
      end
    end
  end
endmodule

// File: tb/tb_lsu_queue.sv
`timescale 1ns/1ps
// Scoreboard bench for lsu_queue: a byte-level memory model predicts beats
// and responses; a monitor checks them as the DUT presents them.
module tb_lsu_queue;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TID_W  = 2;
  localparam int unsigned BYTES  = DATA_W / 8;

  logic              clk, a_rst;
  logic [ADDR_W-1:0] rq_addr;
  logic              rq_wr_addr, rq_width, rq_cmd, rq_start, rq_ack;
  logic [DATA_W-1:0] rq_data;
  logic [TID_W-1:0]  rq_t_id;
  logic              mem_rdy, mem_cmd, mem_bus_assert;
  logic [DATA_W-1:0] mem_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTES-1:0]  mem_be;
  logic              rsp_valid, lsu_idle;
  logic [DATA_W-1:0] rsp_data;
  logic [TID_W-1:0]  rsp_t_id;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [BYTES-1:0]  be;
    logic              cmd;
    logic [DATA_W-1:0] wdata;
    logic              last;
  } beat_t;

  typedef struct {
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] data;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  logic [7:0] model_mem [65536];
  logic [7:0] bus_mem   [65536];
  int n_vec = 0, n_bad = 0;
  int m_acc = 0, m_pop = 0, acc_seen = 0, rdy_mode = 0;
  logic [ADDR_W-1:0] last_model = '0;

  lsu_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TID_W(TID_W)) dut (
    .clk(clk), .a_rst(a_rst),
    .rq_addr(rq_addr), .rq_wr_addr(rq_wr_addr), .rq_data(rq_data),
    .rq_width(rq_width), .rq_cmd(rq_cmd), .rq_t_id(rq_t_id),
    .rq_start(rq_start), .rq_ack(rq_ack),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_cmd(mem_cmd), .mem_be(mem_be),
    .mem_bus_assert(mem_bus_assert),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_t_id(rsp_t_id),
    .lsu_idle(lsu_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] lane_mask(input logic [BYTES-1:0] be);
    logic [DATA_W-1:0] m;
    for (int j = 0; j < BYTES; j++) m[j*8 +: 8] = {8{be[j]}};
    return m;
  endfunction

  // Expected beats are grouped byte by byte; reads see all earlier writes.
  task automatic model_accept(input logic [ADDR_W-1:0] addr, input logic wa,
                              input logic [DATA_W-1:0] data, input logic width,
                              input logic cmd, input logic [TID_W-1:0] tid);
    logic [ADDR_W-1:0] a, ba, bbase;
    beat_t cur;
    rsp_t r;
    int n, lane;
    a = wa ? addr : last_model;
    last_model = a;
    n = width ? 1 : int'(BYTES);
    r.tid = tid;
    r.data = '0;
    cur = '{addr: '0, be: '0, cmd: cmd, wdata: '0, last: 1'b0};
    for (int i = 0; i < n; i++) begin
      ba = a + ADDR_W'(i);
      bbase = ba & ~ADDR_W'(BYTES - 1);
      lane = int'(ba) % int'(BYTES);
      if (i == 0 || bbase != cur.addr) begin
        if (i != 0) beat_q.push_back(cur);
        cur = '{addr: bbase, be: '0, cmd: cmd, wdata: '0, last: 1'b0};
      end
      cur.be[lane] = 1'b1;
      if (cmd) begin
        cur.wdata[lane*8 +: 8] = data[i*8 +: 8];
        model_mem[ba] = data[i*8 +: 8];
      end else begin
        r.data[i*8 +: 8] = model_mem[ba];
      end
    end
    cur.last = 1'b1;
    beat_q.push_back(cur);
    rsp_q.push_back(r);
    acc_seen++;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [ADDR_W-1:0] addr, input logic wa,
                      input logic [DATA_W-1:0] data, input logic width,
                      input logic cmd, input logic [TID_W-1:0] tid);
    int waited = 0;
    bit done = 0;
    rq_addr = addr; rq_wr_addr = wa; rq_data = data;
    rq_width = width; rq_cmd = cmd; rq_t_id = tid; rq_start = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (rq_ack) begin
        model_accept(addr, wa, data, width, cmd, tid);
        done = 1;
      end else if (waited++ >= 300) begin
        chk("rq_ack_timeout", 64'(rq_ack), 64'd1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    rq_start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((beat_q.size() != 0 || rsp_q.size() != 0 || !lsu_idle) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_idle", 64'(lsu_idle), 64'd1);
    chk("drain_rsp_left", 64'(rsp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Memory responder: ready per mode, read lanes come from the bus-side memory.
  always @(posedge clk) begin
    #2;
    mem_rdy = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 9) < 6);
    for (int j = 0; j < BYTES; j++)
      mem_rdata[j*8 +: 8] = bus_mem[mem_addr + ADDR_W'(j)];
  end

  // Monitor: acceptance, bus beats and responses against the scoreboard.
  always @(negedge clk) begin
    beat_t b;
    rsp_t r;
    logic exp_ack;
    if (a_rst) begin
      exp_ack = rq_start && ((m_acc - m_pop) < int'(DEPTH));
      chk("rq_ack", 64'(rq_ack), 64'(exp_ack));
      if (rq_ack) m_acc++;
      if (mem_bus_assert) begin
        if (beat_q.size() == 0) chk("spurious_beat", 64'(mem_bus_assert), 64'd0);
        else begin
          b = beat_q[0];
          chk("mem_addr", 64'(mem_addr), 64'(b.addr));
          chk("mem_be", 64'(mem_be), 64'(b.be));
          chk("mem_cmd", 64'(mem_cmd), 64'(b.cmd));
          if (b.cmd) chk("mem_wdata", 64'(mem_wdata & lane_mask(b.be)), 64'(b.wdata));
          if (mem_rdy) begin
            if (mem_cmd)
              for (int j = 0; j < BYTES; j++)
                if (mem_be[j]) bus_mem[mem_addr + ADDR_W'(j)] = mem_wdata[j*8 +: 8];
            void'(beat_q.pop_front());
            if (b.last) m_pop++;
          end
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("spurious_rsp", 64'(rsp_valid), 64'd0);
        else begin
          r = rsp_q.pop_front();
          chk("rsp_t_id", 64'(rsp_t_id), 64'(r.tid));
          chk("rsp_data", 64'(rsp_data), 64'(r.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench did not terminate");
  end

  initial begin
    logic [6:0] bus_pat, rsp_pat;
    int acc0, t, cnt;
    for (int i = 0; i < 65536; i++) begin
      model_mem[i] = 8'(i * 37) ^ 8'(i >> 8);
      bus_mem[i]   = model_mem[i];
    end
    a_rst = 1'b0; rq_start = 1'b0; rq_addr = '0; rq_wr_addr = 1'b0;
    rq_data = '0; rq_width = 1'b0; rq_cmd = 1'b0; rq_t_id = '0;
    mem_rdy = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_bus", 64'(mem_bus_assert), 64'd0);
    chk("rst_be", 64'(mem_be), 64'd0);
    chk("rst_cmd", 64'(mem_cmd), 64'd0);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_idle", 64'(lsu_idle), 64'd1);
    chk("rst_ack", 64'(rq_ack), 64'd0);
    repeat (2) @(posedge clk);
    #3 a_rst = 1'b1;
    @(posedge clk); #1;

    // Latency into an empty queue with immediate ready.
    rdy_mode = 1;
    send(16'h0040, 1'b1, '0, 1'b0, 1'b0, 2'd1);
    @(negedge clk);
    chk("lat_bus", 64'(mem_bus_assert), 64'd1);
    chk("lat_idle", 64'(lsu_idle), 64'd0);
    @(negedge clk);
    chk("lat_rsp", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;

    rdy_mode = 2;
    send(16'h0041, 1'b1, 32'h0000_00AB, 1'b1, 1'b1, 2'd2);
    send(16'h0102, 1'b1, '0, 1'b0, 1'b0, 2'd3);
    send(16'hFFFE, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd0);
    send(16'hFFFE, 1'b1, '0, 1'b0, 1'b0, 2'd1);
    send(16'h0200, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 2'd2);
    send(16'h1234, 1'b0, '0, 1'b0, 1'b0, 2'd3);
    send(16'h0103, 1'b1, '0, 1'b1, 1'b0, 2'd0);
    drain();

    // Full queue: fifth request waits for the first pop, then no bubbles.
    rdy_mode = 0;
    acc0 = acc_seen;
    fork
      begin
        for (int k = 0; k < 5; k++)
          send(ADDR_W'(16'h0100 + 4 * k), 1'b1, '0, 1'b0, 1'b0, TID_W'(k));
      end
      begin
        t = 0;
        while (acc_seen - acc0 < 4 && t < 50) begin
          @(posedge clk);
          t++;
        end
        repeat (3) @(posedge clk);
        #1 rdy_mode = 1;
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          bus_pat[i] = mem_bus_assert;
          rsp_pat[i] = rsp_valid;
        end
      end
    join
    chk("full_bus_pattern", 64'(bus_pat), 64'(7'b0011111));
    chk("full_rsp_pattern", 64'(rsp_pat), 64'(7'b0111110));
    drain();

    rdy_mode = 2;
    for (int n = 0; n < 400; n++) begin
      logic [ADDR_W-1:0] a;
      if ($urandom_range(0, 3) == 0) a = 16'hFFF8 + ADDR_W'($urandom_range(0, 7));
      else                           a = 16'h0100 + ADDR_W'($urandom_range(0, 47));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      send(a, ($urandom_range(0, 3) != 0), DATA_W'($urandom), 1'($urandom),
           1'($urandom), TID_W'($urandom));
    end
    drain();

    // Reset in the middle of a stalled beat.
    rdy_mode = 0;
    send(16'h0300, 1'b1, '0, 1'b0, 1'b0, 2'd1);
    @(posedge clk); #3;
    a_rst = 1'b0;
    #1;
    chk("midrst_bus", 64'(mem_bus_assert), 64'd0);
    chk("midrst_be", 64'(mem_be), 64'd0);
    chk("midrst_idle", 64'(lsu_idle), 64'd1);
    beat_q.delete();
    rsp_q.delete();
    m_acc = 0; m_pop = 0; last_model = '0;
    @(posedge clk); #3;
    a_rst = 1'b1;
    rdy_mode = 2;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("midrst_no_rsp", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    send(16'h5555, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1, 2'd2);
    send(16'h0000, 1'b1, '0, 1'b0, 1'b0, 2'd3);
    drain();
    chk("end_idle", 64'(lsu_idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
